alu_ctrl_exec_unit: RTL and testbench
=====================================

Name: alu_ctrl_exec_unit

Overview:
Execute-stage core of the single-cycle MIPS-subset CPU.
- Decodes the instruction into datapath controls (CONUNIT function).
- Runs the 32-bit ALU, whose add/sub path is built on a 32-bit carry-lookahead adder (CLA_32 function).
- Computes the beq/bne branch target with a second CLA instance.
- All outputs are registered once, giving 1-cycle latency, for timing-isolated verification.

Parameters:
WIDTH, 32, datapath width (fixed at 32; other values unsupported)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-low reset
inst  in  32  instruction word
qa  in  32  register-file read port A (rs)
qb  in  32  register-file read port B (rt)
pc_plus4  in  32  PC+4 of this instruction
regrt  out  1  1 = write-register is rt (inst[20:16]); 0 = rd (inst[15:11])
se  out  1  1 = sign-extend imm16; 0 = zero-extend
wreg  out  1  register-file write enable
aluqb  out  1  1 = ALU B from qb; 0 = B from extended immediate
aluc  out  3  ALU op code
wmem  out  1  data-memory write enable
pcsrc  out  3  next-PC select
reg2reg  out  1  1 = write-back ALU result; 0 = memory data
alu_r  out  32  ALU result
z  out  1  alu_r == 0
br_target  out  32  pc_plus4 + (ext(imm16) << 2)
br_cout  out  1  carry-out of the branch-target adder

Behaviour:
Clocking and reset:
- All outputs are flops updated on rising Clk from the combinational values of the current inputs; latency is 1 cycle.
- Reset == 0 at a rising edge clears every output to 0. Reset has priority over data.
- Combinational decode, ALU and adders ignore Reset.

Decode (op = inst[31:26], fn = inst[5:0]). Listed fields are 1 / values; every field not listed is 0.
- R-type, op 000000, all: regrt 0, aluqb 1, pcsrc 000.
  - add 100000: wreg 1, reg2reg 1, aluc 000.
  - sub 100010: wreg 1, reg2reg 1, aluc 001.
  - and 100100: wreg 1, reg2reg 1, aluc 010.
  - or 100101: wreg 1, reg2reg 1, aluc 011.
  - slt 101010: wreg 1, reg2reg 1, aluc 100.
  - xor 100110: wreg 1, reg2reg 1, aluc 110.
  - nor 100111: wreg 1, reg2reg 1, aluc 111.
  - jr 001000: wreg 0, pcsrc 100.
- addi 001000: regrt 1, se 1, wreg 1, reg2reg 1, aluc 000.
- andi 001100: regrt 1, wreg 1, reg2reg 1, aluc 010.
- ori 001101: regrt 1, wreg 1, reg2reg 1, aluc 011.
- lui 001111: regrt 1, wreg 1, reg2reg 1, aluc 101.
- lw 100011: regrt 1, se 1, wreg 1, reg2reg 0, aluc 000.
- sw 101011: regrt 1, se 1, wmem 1, aluc 000.
- beq 000100: se 1, aluqb 1, aluc 001; pcsrc 010 if Z else 000.
- bne 000101: se 1, aluqb 1, aluc 001; pcsrc 010 if !Z else 000.
- j 000010: pcsrc 011.
- jal 000011: wreg 1, pcsrc 011.
- Any other op/fn: all controls 0 (NOP). pcsrc 001 is never generated.

ALU (A = qa; B = aluqb ? qb : ext(imm16)):
- 000: A+B
- 001: A-B, computed as A + ~B + 1 through the CLA
- 010: A&B
- 011: A|B
- 100: signed A<B → 1, else 0
- 101: {B[15:0], 16'h0}
- 110: A^B
- 111: ~(A|B)
- Overflow is ignored; results wrap mod 2^32.
- Z = (result == 0), computed combinationally and fed to pcsrc in the same cycle.

CLA_32:
- 32-bit adder with A, B, Ci inputs and S, Co outputs.
- Built from eight 4-bit lookahead groups plus group-level generate/propagate lookahead; no ripple between groups.
- Branch target: pc_plus4 + {ext[29:0], 2'b00}, Ci = 0, wraps mod 2^32. br_cout is that adder's Co.
- br_target is produced for every instruction; it is ext-based regardless of op.

Test Plan:
1. Reset=0 for 2 edges with any inputs → all outputs 0. Then Reset=1 → outputs track inputs 1 cycle later.
2. add, qa=0x7FFFFFFF, qb=1 → alu_r 0x80000000, z 0, wreg 1, regrt 0, reg2reg 1, aluc 000. Repeat with sub, qa=qb=5 → alu_r 0, z 1.
3. slt, qa=0xFFFFFFFF, qb=1 → alu_r 1. lui imm 0x1234 → alu_r 0x12340000. ori qa=0xF0, imm 0x8000 → alu_r 0x000080F0 (zero-extend).
4. beq, qa=qb=3, pc_plus4=0x100, imm 0xFFFF → pcsrc 010, br_target 0x000000FC. Same with qa≠qb → pcsrc 000. bne mirrors both cases.
5. lw → reg2reg 0, se 1, wreg 1. sw → wmem 1, wreg 0. j → pcsrc 011, wreg 0. jal → pcsrc 011, wreg 1. jr → pcsrc 100.
6. Unknown op 111111 → all controls 0. Branch adder with pc_plus4=0xFFFFFFFC, imm 0x0001 → br_target 0x00000000, br_cout 1.

Source files
------------

// File: rtl/alu_ctrl_exec_unit.sv
// Execute-stage core of the single-cycle MIPS-subset CPU: control decode, 32-bit ALU
// and branch-target adder, all outputs registered once (1-cycle latency).

module Cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        ci_i,
    output logic [31:0] s_o,
    output logic        co_o
);
    logic [31:0] g, p, c;
    logic [7:0]  grpG, grpP;
    logic [8:0]  grpC;

    // Flat carry-lookahead expression for the carry after n positions.
    function automatic logic lookahead(input logic [7:0] gv, input logic [7:0] pv,
                                       input logic cin, input int n);
        logic res;
        logic term;
        res = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j < n) begin
                term = gv[j];
                for (int m = 0; m < 8; m++) begin
                    if (m > j && m < n) term = term & pv[m];
                end
                res = res | term;
            end
        end
        term = cin;
        for (int m = 0; m < 8; m++) begin
            if (m < n) term = term & pv[m];
        end
        return res | term;
    endfunction

    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c    = '0;
        grpG = '0;
        grpP = '0;
        grpC = '0;
        for (int k = 0; k < 8; k++) begin
            grpG[k] = lookahead({4'b0, g[k*4 +: 4]}, {4'b0, p[k*4 +: 4]}, 1'b0, 4);
            grpP[k] = &p[k*4 +: 4];
        end
        // Group carries come straight from group G/P and ci, never from a neighbour group.
        grpC[0] = ci_i;
        for (int k = 1; k < 9; k++) begin
            grpC[k] = lookahead(grpG, grpP, ci_i, k);
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                c[k*4 + i] = lookahead({4'b0, g[k*4 +: 4]}, {4'b0, p[k*4 +: 4]}, grpC[k], i);
            end
        end
        s_o  = p ^ c;
        co_o = grpC[8];
    end
endmodule

module alu_ctrl_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] inst,
    input  logic [WIDTH-1:0] qa,
    input  logic [WIDTH-1:0] qb,
    input  logic [WIDTH-1:0] pc_plus4,
    output logic             regrt,
    output logic             se,
    output logic             wreg,
    output logic             aluqb,
    output logic [2:0]       aluc,
    output logic             wmem,
    output logic [2:0]       pcsrc,
    output logic             reg2reg,
    output logic [WIDTH-1:0] alu_r,
    output logic             z,
    output logic [WIDTH-1:0] br_target,
    output logic             br_cout
);
    logic [5:0]  op, fn;
    logic [15:0] imm;
    logic        regrt_d, se_d, wreg_d, aluqb_d, wmem_d, reg2reg_d, isBeq, isBne;
    logic [2:0]  aluc_d, pcsrcBase, pcsrc_d;
    logic [31:0] ext, aluB, addB, addSum, aluR_d, brSum;
    logic        z_d, brCout_d, aluCoutUnused, unusedInstBits;

    logic        regrt_q, se_q, wreg_q, aluqb_q, wmem_q, reg2reg_q, z_q, brCout_q;
    logic [2:0]  aluc_q, pcsrc_q;
    logic [31:0] aluR_q, brTarget_q;

    assign op  = inst[31:26];
    assign fn  = inst[5:0];
    assign imm = inst[15:0];
    assign unusedInstBits = ^inst[25:16];

    always_comb begin
        regrt_d   = 1'b0;
        se_d      = 1'b0;
        wreg_d    = 1'b0;
        aluqb_d   = 1'b0;
        aluc_d    = 3'b000;
        wmem_d    = 1'b0;
        pcsrcBase = 3'b000;
        reg2reg_d = 1'b0;
        isBeq     = 1'b0;
        isBne     = 1'b0;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: begin aluqb_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b000; end
                    6'b100010: begin aluqb_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b001; end
                    6'b100100: begin aluqb_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b010; end
                    6'b100101: begin aluqb_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b011; end
                    6'b101010: begin aluqb_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b100; end
                    6'b100110: begin aluqb_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b110; end
                    6'b100111: begin aluqb_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b111; end
                    6'b001000: begin aluqb_d = 1'b1; pcsrcBase = 3'b100; end
                    default: ;
                endcase
            end
            6'b001000: begin regrt_d = 1'b1; se_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b000; end
            6'b001100: begin regrt_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b010; end
            6'b001101: begin regrt_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b011; end
            6'b001111: begin regrt_d = 1'b1; wreg_d = 1'b1; reg2reg_d = 1'b1; aluc_d = 3'b101; end
            6'b100011: begin regrt_d = 1'b1; se_d = 1'b1; wreg_d = 1'b1; aluc_d = 3'b000; end
            6'b101011: begin regrt_d = 1'b1; se_d = 1'b1; wmem_d = 1'b1; aluc_d = 3'b000; end
            6'b000100: begin se_d = 1'b1; aluqb_d = 1'b1; aluc_d = 3'b001; isBeq = 1'b1; end
            6'b000101: begin se_d = 1'b1; aluqb_d = 1'b1; aluc_d = 3'b001; isBne = 1'b1; end
            6'b000010: begin pcsrcBase = 3'b011; end
            6'b000011: begin wreg_d = 1'b1; pcsrcBase = 3'b011; end
            default: ;
        endcase
    end

    assign ext  = se_d ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    assign aluB = aluqb_d ? qb : ext;
    // Subtract reuses the adder as A + ~B + 1.
    assign addB = (aluc_d == 3'b001) ? ~aluB : aluB;

    Cla32 uAluAdder (
        .a_i (qa),
        .b_i (addB),
        .ci_i(aluc_d == 3'b001),
        .s_o (addSum),
        .co_o(aluCoutUnused)
    );

    Cla32 uBranchAdder (
        .a_i (pc_plus4),
        .b_i ({ext[29:0], 2'b00}),
        .ci_i(1'b0),
        .s_o (brSum),
        .co_o(brCout_d)
    );

    always_comb begin
        aluR_d = addSum;
        case (aluc_d)
            3'b010:  aluR_d = qa & aluB;
            3'b011:  aluR_d = qa | aluB;
            3'b100:  aluR_d = {31'b0, $signed(qa) < $signed(aluB)};
            3'b101:  aluR_d = {aluB[15:0], 16'h0000};
            3'b110:  aluR_d = qa ^ aluB;
            3'b111:  aluR_d = ~(qa | aluB);
            default: aluR_d = addSum;
        endcase
    end

    assign z_d     = (aluR_d == 32'h0);
    // Branch decision lives outside the decode block so zero can feed it without a comb loop.
    assign pcsrc_d = ((isBeq && z_d) || (isBne && !z_d)) ? 3'b010 : pcsrcBase;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            regrt_q    <= 1'b0;
            se_q       <= 1'b0;
            wreg_q     <= 1'b0;
            aluqb_q    <= 1'b0;
            aluc_q     <= 3'b000;
            wmem_q     <= 1'b0;
            pcsrc_q    <= 3'b000;
            reg2reg_q  <= 1'b0;
            aluR_q     <= 32'h0;
            z_q        <= 1'b0;
            brTarget_q <= 32'h0;
            brCout_q   <= 1'b0;
        end else begin
            regrt_q    <= regrt_d;
            se_q       <= se_d;
            wreg_q     <= wreg_d;
            aluqb_q    <= aluqb_d;
            aluc_q     <= aluc_d;
            wmem_q     <= wmem_d;
            pcsrc_q    <= pcsrc_d;
            reg2reg_q  <= reg2reg_d;
            aluR_q     <= aluR_d;
            z_q        <= z_d;
            brTarget_q <= brSum;
            brCout_q   <= brCout_d;
        end
    end

    assign regrt     = regrt_q;
    assign se        = se_q;
    assign wreg      = wreg_q;
    assign aluqb     = aluqb_q;
    assign aluc      = aluc_q;
    assign wmem      = wmem_q;
    assign pcsrc     = pcsrc_q;
    assign reg2reg   = reg2reg_q;
    assign alu_r     = aluR_q;
    assign z         = z_q;
    assign br_target = brTarget_q;
    assign br_cout   = brCout_q;
endmodule

// File: tb/tb_alu_ctrl_exec_unit.sv
// Scoreboard bench for alu_ctrl_exec_unit: directed vectors push hand-computed
// expectations; a monitor pops and compares one cycle after each vector is captured.

module tb_alu_ctrl_exec_unit;
    typedef struct packed {
        logic       regrt;
        logic       se;
        logic       wreg;
        logic       aluqb;
        logic [2:0] aluc;
        logic       wmem;
        logic [2:0] pcsrc;
        logic       reg2reg;
    } ctrl_t;

    typedef struct packed {
        logic [7:0]  id;
        ctrl_t       ctrl;
        logic [31:0] r;
        logic        z;
        logic [31:0] bt;
        logic        bc;
    } exp_t;

    logic        Clk, Reset;
    logic [31:0] inst, qa, qb, pc_plus4;
    logic        regrt, se, wreg, aluqb, wmem, reg2reg, z, br_cout;
    logic [2:0]  aluc, pcsrc;
    logic [31:0] alu_r, br_target;

    int   checks   = 0;
    int   failures = 0;
    int   vecId    = 0;
    exp_t expQ[$];

    alu_ctrl_exec_unit #(.WIDTH(32)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .inst     (inst),
        .qa       (qa),
        .qb       (qb),
        .pc_plus4 (pc_plus4),
        .regrt    (regrt),
        .se       (se),
        .wreg     (wreg),
        .aluqb    (aluqb),
        .aluc     (aluc),
        .wmem     (wmem),
        .pcsrc    (pcsrc),
        .reg2reg  (reg2reg),
        .alu_r    (alu_r),
        .z        (z),
        .br_target(br_target),
        .br_cout  (br_cout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'b0, imm};
    endfunction

    function automatic logic [31:0] rType(input logic [5:0] fn);
        return {26'b0, fn};
    endfunction

    function automatic ctrl_t mkCtrl(input logic regrtE, input logic seE, input logic wregE,
                                     input logic aluqbE, input logic [2:0] alucE, input logic wmemE,
                                     input logic [2:0] pcsrcE, input logic reg2regE);
        ctrl_t c;
        c.regrt = regrtE; c.se = seE; c.wreg = wregE; c.aluqb = aluqbE;
        c.aluc = alucE; c.wmem = wmemE; c.pcsrc = pcsrcE; c.reg2reg = reg2regE;
        return c;
    endfunction

    // Drive one vector on the falling edge and queue what the outputs must become.
    task automatic applyStimulus(input logic rst, input logic [31:0] instV, input logic [31:0] qaV,
                                 input logic [31:0] qbV, input logic [31:0] pcV, input ctrl_t c,
                                 input logic [31:0] r, input logic zV, input logic [31:0] bt,
                                 input logic bc);
        exp_t e;
        @(negedge Clk);
        Reset = rst; inst = instV; qa = qaV; qb = qbV; pc_plus4 = pcV;
        vecId++;
        e.id = 8'(vecId); e.ctrl = c; e.r = r; e.z = zV; e.bt = bt; e.bc = bc;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int id, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL vec%0d %s: got 0x%08h required 0x%08h", id, name, act, req);
        end
    endtask

    // Monitor: each output sample after a capture edge is matched against the oldest expectation.
    initial begin
        exp_t e;
        ctrl_t act;
        forever begin
            @(posedge Clk);
            #1;
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                act = {regrt, se, wreg, aluqb, aluc, wmem, pcsrc, reg2reg};
                checkOutput("ctrl", int'(e.id), {20'b0, act}, {20'b0, e.ctrl});
                checkOutput("alu_r", int'(e.id), alu_r, e.r);
                checkOutput("z", int'(e.id), {31'b0, z}, {31'b0, e.z});
                checkOutput("br_target", int'(e.id), br_target, e.bt);
                checkOutput("br_cout", int'(e.id), {31'b0, br_cout}, {31'b0, e.bc});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ctrl_t zero, rAlu;
        zero = mkCtrl(0, 0, 0, 0, 3'b000, 0, 3'b000, 0);
        Reset = 1'b0; inst = '0; qa = '0; qb = '0; pc_plus4 = '0;

        applyStimulus(0, rType(6'h20), 32'h1, 32'h2, 32'h100, zero, 32'h0, 0, 32'h0, 0);
        applyStimulus(0, rType(6'h20), 32'h1, 32'h2, 32'h100, zero, 32'h0, 0, 32'h0, 0);

        rAlu = mkCtrl(0, 0, 1, 1, 3'b000, 0, 3'b000, 1);
        applyStimulus(1, rType(6'h20), 32'h7FFFFFFF, 32'h1, 32'h100, rAlu, 32'h80000000, 0, 32'h180, 0);
        rAlu.aluc = 3'b001;
        applyStimulus(1, rType(6'h22), 32'h5, 32'h5, 32'h100, rAlu, 32'h0, 1, 32'h188, 0);
        rAlu.aluc = 3'b100;
        applyStimulus(1, rType(6'h2A), 32'hFFFFFFFF, 32'h1, 32'h100, rAlu, 32'h1, 0, 32'h1A8, 0);
        rAlu.aluc = 3'b010;
        applyStimulus(1, rType(6'h24), 32'hF0F0, 32'hFF00, 32'h100, rAlu, 32'hF000, 0, 32'h190, 0);
        rAlu.aluc = 3'b011;
        applyStimulus(1, rType(6'h25), 32'hF0, 32'h0F, 32'h100, rAlu, 32'hFF, 0, 32'h194, 0);
        rAlu.aluc = 3'b110;
        applyStimulus(1, rType(6'h26), 32'hFF, 32'h0F, 32'h100, rAlu, 32'hF0, 0, 32'h198, 0);
        rAlu.aluc = 3'b111;
        applyStimulus(1, rType(6'h27), 32'h0, 32'h0, 32'h100, rAlu, 32'hFFFFFFFF, 0, 32'h19C, 0);

        applyStimulus(1, iType(6'h0F, 16'h1234), 32'h55, 32'h0, 32'h100,
                      mkCtrl(1, 0, 1, 0, 3'b101, 0, 3'b000, 1), 32'h12340000, 0, 32'h49D0, 0);
        applyStimulus(1, iType(6'h0D, 16'h8000), 32'hF0, 32'h0, 32'h100,
                      mkCtrl(1, 0, 1, 0, 3'b011, 0, 3'b000, 1), 32'h80F0, 0, 32'h20100, 0);
        applyStimulus(1, iType(6'h08, 16'hFFFF), 32'hA, 32'h0, 32'h100,
                      mkCtrl(1, 1, 1, 0, 3'b000, 0, 3'b000, 1), 32'h9, 0, 32'hFC, 1);

        applyStimulus(1, iType(6'h04, 16'hFFFF), 32'h3, 32'h3, 32'h100,
                      mkCtrl(0, 1, 0, 1, 3'b001, 0, 3'b010, 0), 32'h0, 1, 32'hFC, 1);
        applyStimulus(1, iType(6'h04, 16'hFFFF), 32'h3, 32'h4, 32'h100,
                      mkCtrl(0, 1, 0, 1, 3'b001, 0, 3'b000, 0), 32'hFFFFFFFF, 0, 32'hFC, 1);
        applyStimulus(1, iType(6'h05, 16'hFFFF), 32'h3, 32'h3, 32'h100,
                      mkCtrl(0, 1, 0, 1, 3'b001, 0, 3'b000, 0), 32'h0, 1, 32'hFC, 1);
        applyStimulus(1, iType(6'h05, 16'hFFFF), 32'h3, 32'h4, 32'h100,
                      mkCtrl(0, 1, 0, 1, 3'b001, 0, 3'b010, 0), 32'hFFFFFFFF, 0, 32'hFC, 1);

        applyStimulus(1, iType(6'h23, 16'h0010), 32'h1000, 32'h0, 32'h100,
                      mkCtrl(1, 1, 1, 0, 3'b000, 0, 3'b000, 0), 32'h1010, 0, 32'h140, 0);
        applyStimulus(1, iType(6'h2B, 16'hFFFC), 32'h1000, 32'h0, 32'h100,
                      mkCtrl(1, 1, 0, 0, 3'b000, 1, 3'b000, 0), 32'hFFC, 0, 32'hF0, 1);
        applyStimulus(1, iType(6'h02, 16'h0040), 32'h0, 32'h0, 32'h100,
                      mkCtrl(0, 0, 0, 0, 3'b000, 0, 3'b011, 0), 32'h40, 0, 32'h200, 0);
        applyStimulus(1, iType(6'h03, 16'h0040), 32'h0, 32'h0, 32'h100,
                      mkCtrl(0, 0, 1, 0, 3'b000, 0, 3'b011, 0), 32'h40, 0, 32'h200, 0);
        applyStimulus(1, rType(6'h08), 32'h400, 32'h0, 32'h100,
                      mkCtrl(0, 0, 0, 1, 3'b000, 0, 3'b100, 0), 32'h400, 0, 32'h120, 0);

        applyStimulus(1, iType(6'h3F, 16'h0001), 32'h5, 32'h6, 32'hFFFFFFFC, zero, 32'h6, 0, 32'h0, 1);
        applyStimulus(1, rType(6'h3F), 32'h5, 32'h6, 32'h100, zero, 32'h44, 0, 32'h1FC, 0);

        applyStimulus(0, rType(6'h20), 32'h7, 32'h8, 32'h100, zero, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, rType(6'h20), 32'h7, 32'h8, 32'h100,
                      mkCtrl(0, 0, 1, 1, 3'b000, 0, 3'b000, 1), 32'hF, 0, 32'h180, 0);

        repeat (3) @(negedge Clk);
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
